turf_wb_master: RTL and testbench
=================================

Name: turf_wb_master

Overview:
- Wishbone initiator that turns the 32-bit command word stream from the TURF link into single Wishbone read/write cycles on the 12-bit-address, 32-bit-data register bus.
- Returns one tagged response word per completed transaction for the TURF response path.
- Sits between the TURF command outputs (command, command_valid) and the Wishbone target port of the SURF/TURF interface fan-out.
- Commands are accepted only when idle; surplus commands are dropped and counted.

Parameters:
- TIMEOUT, 255: maximum cycles stb may stay asserted without ack/err before the cycle is abandoned (1..255).
- SEL_DEFAULT, 4'hF: byte-select driven on every cycle.

Ports:
- wb_clk_i  in  1  clock for all logic.
- wb_rstn_i  in  1  asynchronous reset, active-low.
- command_i  in  32  command word from the TURF link.
- command_valid_i  in  1  command_i is valid this cycle. Single-cycle pulse, no backpressure.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  12  address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte select.
- wb_ack_i  in  1  target acknowledge.
- wb_err_i  in  1  target error.
- wb_dat_i  in  32  read data.
- resp_o  out  32  response data: read data, or 0 for writes and errors.
- resp_tag_o  out  7  tag copied from the header.
- resp_err_o  out  1  transaction ended by wb_err_i or timeout.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  response consumed.
- drop_count_o  out  8  saturating count of dropped command words.

Behaviour:
- Reset (wb_rstn_i low, asynchronous): state IDLE; all outputs 0 except wb_sel_o = SEL_DEFAULT. Release is synchronous to wb_clk_i. Reset mid-cycle drops cyc/stb immediately and discards the transaction with no response.
- Header word layout:
  - [31] = write.
  - [30:24] = tag.
  - [23:12] ignored.
  - [11:0] = address.
- States: IDLE, WDATA, CYCLE, RESP.
- IDLE:
  - On command_valid_i, latch adr, tag and write.
  - Write: go to WDATA.
  - Read: go to CYCLE with cyc/stb/we=0 high the next cycle, i.e. header at edge N gives stb high during N+1.
- WDATA:
  - The next command_valid_i word is write data; latch it into wb_dat_o.
  - Go to CYCLE with cyc/stb/we=1 asserted the following cycle.
  - WDATA has no timeout.
- CYCLE:
  - cyc, stb, adr, we and dat are held constant.
  - A timeout counter is cleared on entry and increments each cycle stb is high.
  - Edge where wb_ack_i or wb_err_i is sampled high: cyc/stb deassert the next cycle, no back-to-back cycles; capture wb_dat_i into resp_o for reads (0 for writes); resp_err_o = wb_err_i; go to RESP. resp_valid_o rises in the same cycle cyc falls.
  - Counter reaching TIMEOUT with no ack/err: cyc/stb drop, resp_err_o = 1, resp_o = 0, go to RESP.
  - Simultaneous events: err and ack together → error wins, resp_o = 0. Ack on the same edge as the counter reaching TIMEOUT → ack wins, no error.
- RESP:
  - resp_valid_o is held with resp_o/resp_tag_o/resp_err_o stable until resp_ready_i is sampled high.
  - resp_valid_o then clears next cycle and the state returns to IDLE.
  - A new header is accepted on the first cycle back in IDLE.
- Dropping: any command_valid_i in CYCLE or RESP is discarded and increments drop_count_o, which saturates at 255 and never wraps. Cleared only by reset.

Test Plan:
- Read: header 32'h05000040, target acks 3 cycles after stb → one cycle with adr=12'h040, we=0; resp_o = target data 32'h12345678, resp_tag_o=7'h05, resp_err_o=0; cyc low the cycle resp_valid rises.
- Write: header 32'h8A000104 then data 32'hCAFEBABE → stb with we=1, adr=12'h104, dat=32'hCAFEBABE, sel=4'hF; response resp_o=0, tag=7'h0A.
- Timeout: read header, target never responds → stb high exactly TIMEOUT=255 cycles, then resp_err_o=1, resp_o=0. Same case with ack on cycle 255 → no error.
- Err and ack asserted together → resp_err_o=1, resp_o=0.
- Drops: 300 headers pulsed while resp_ready_i held low in RESP → drop_count_o=255 (saturated); after ready, the next header executes normally.
- Reset asserted during CYCLE → wb_cyc_o/wb_stb_o low immediately, no response; a post-reset read completes normally.

Source files
------------

// File: rtl/turf_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : turf_wb_master
//  Description : Wishbone initiator that converts TURF command words into
//                single read/write cycles on a 12-bit-address, 32-bit-data
//                register bus and returns one tagged response per cycle.
//                Commands arriving while a transaction is in flight are
//                dropped and counted (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module turf_wb_master #(
    parameter int         TIMEOUT     = 255,
    parameter logic [3:0] SEL_DEFAULT = 4'hF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic [31:0] command_i,
    input  logic        command_valid_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [11:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] resp_o,
    output logic [6:0]  resp_tag_o,
    output logic        resp_err_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [7:0]  drop_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_CYCLE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Timeout compared one bit wider so the increment can never wrap.
    localparam logic [8:0] c_timeout = 9'(TIMEOUT);

    // Header bit positions
    localparam int c_hdr_write = 31;

    logic [1:0]  r_rst_sync;
    logic        w_rst_n;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [11:0] r_adr;
    logic [31:0] r_dat;
    logic [6:0]  r_tag;
    logic [31:0] r_resp;
    logic        r_resp_err;
    logic [7:0]  r_cnt;
    logic [7:0]  r_drop;

    logic        w_we_next;
    logic [11:0] w_adr_next;
    logic [31:0] w_dat_next;
    logic [6:0]  w_tag_next;
    logic [31:0] w_resp_next;
    logic        w_resp_err_next;
    logic [7:0]  w_cnt_next;

    logic [8:0]  w_cnt_inc;
    logic        w_timeout;
    logic        w_drop_event;
    logic        w_unused_hdr;

    // Header bits [23:12] carry no meaning for this block.
    assign w_unused_hdr = ^command_i[23:12];

    // Reset synchroniser: assertion is immediate, release aligns to the clock.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_cnt_inc    = {1'b0, r_cnt} + 9'd1;
    assign w_timeout    = (w_cnt_inc == c_timeout);
    assign w_drop_event = command_valid_i &&
                          ((r_state == ST_CYCLE) || (r_state == ST_RESP));

    // State register.
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath-update decode.
    always_comb begin
        w_state_next    = r_state;
        w_we_next       = r_we;
        w_adr_next      = r_adr;
        w_dat_next      = r_dat;
        w_tag_next      = r_tag;
        w_resp_next     = r_resp;
        w_resp_err_next = r_resp_err;
        w_cnt_next      = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (command_valid_i) begin
                    w_we_next  = command_i[c_hdr_write];
                    w_tag_next = command_i[30:24];
                    w_adr_next = command_i[11:0];
                    w_cnt_next = 8'd0;
                    if (command_i[c_hdr_write]) begin
                        w_state_next = ST_WDATA;
                    end else begin
                        w_state_next = ST_CYCLE;
                    end
                end
            end

            ST_WDATA: begin
                if (command_valid_i) begin
                    w_dat_next   = command_i;
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_CYCLE;
                end
            end

            ST_CYCLE: begin
                // Priority: error, then acknowledge, then timeout.
                if (wb_err_i) begin
                    w_resp_next     = 32'd0;
                    w_resp_err_next = 1'b1;
                    w_state_next    = ST_RESP;
                end else if (wb_ack_i) begin
                    w_resp_next     = r_we ? 32'd0 : wb_dat_i;
                    w_resp_err_next = 1'b0;
                    w_state_next    = ST_RESP;
                end else if (w_timeout) begin
                    w_resp_next     = 32'd0;
                    w_resp_err_next = 1'b1;
                    w_state_next    = ST_RESP;
                end else begin
                    w_cnt_next = w_cnt_inc[7:0];
                end
            end

            ST_RESP: begin
                if (resp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Transaction and response registers.
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_we       <= 1'b0;
            r_adr      <= 12'd0;
            r_dat      <= 32'd0;
            r_tag      <= 7'd0;
            r_resp     <= 32'd0;
            r_resp_err <= 1'b0;
            r_cnt      <= 8'd0;
        end else begin
            r_we       <= w_we_next;
            r_adr      <= w_adr_next;
            r_dat      <= w_dat_next;
            r_tag      <= w_tag_next;
            r_resp     <= w_resp_next;
            r_resp_err <= w_resp_err_next;
            r_cnt      <= w_cnt_next;
        end
    end

    // Saturating count of commands that arrived while busy.
    always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_drop <= 8'd0;
        end else if (w_drop_event && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    // Bus strobes follow the state directly so reset removes them at once.
    assign wb_cyc_o     = (r_state == ST_CYCLE);
    assign wb_stb_o     = (r_state == ST_CYCLE);
    assign wb_we_o      = r_we;
    assign wb_adr_o     = r_adr;
    assign wb_dat_o     = r_dat;
    assign wb_sel_o     = SEL_DEFAULT;

    assign resp_o       = r_resp;
    assign resp_tag_o   = r_tag;
    assign resp_err_o   = r_resp_err;
    assign resp_valid_o = (r_state == ST_RESP);
    assign drop_count_o = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_turf_wb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_turf_wb_master
//  Description : Self-checking bench for turf_wb_master with a transaction
//                level reference model, directed cases and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_turf_wb_master;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [31:0] command = 32'd0;
    logic        cv = 1'b0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [31:0] dat_i = 32'd0;
    logic        ready = 1'b0;

    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [11:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] resp_o;
    logic [6:0]  resp_tag_o;
    logic        resp_err_o, resp_valid_o;
    logic [7:0]  drop_count_o;

    always #5 clk = ~clk;

    turf_wb_master #(.TIMEOUT(TIMEOUT), .SEL_DEFAULT(4'hF)) dut (
        .wb_clk_i        (clk),
        .wb_rstn_i       (rstn),
        .command_i       (command),
        .command_valid_i (cv),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_o        (wb_sel_o),
        .wb_ack_i        (ack),
        .wb_err_i        (err),
        .wb_dat_i        (dat_i),
        .resp_o          (resp_o),
        .resp_tag_o      (resp_tag_o),
        .resp_err_o      (resp_err_o),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (ready),
        .drop_count_o    (drop_count_o)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Phase: 0 waiting for header, 1 waiting for write
    // data, 2 bus transfer in progress, 3 response held for the consumer.
    // ------------------------------------------------------------------
    int          m_phase = 0;
    int          m_cnt   = 0;
    logic        m_we    = 1'b0;
    logic [6:0]  m_tag   = 7'd0;
    logic [11:0] m_adr   = 12'd0;
    logic [31:0] m_dat   = 32'd0;
    logic [31:0] m_resp  = 32'd0;
    logic        m_err   = 1'b0;
    int          m_drop  = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase = 0; m_cnt = 0; m_we = 1'b0; m_tag = 7'd0; m_adr = 12'd0;
            m_dat = 32'd0; m_resp = 32'd0; m_err = 1'b0; m_drop = 0;
        end else begin
            if (cv && (m_phase >= 2) && (m_drop < 255)) m_drop = m_drop + 1;
            if (m_phase == 0) begin
                if (cv) begin
                    m_we  = command[31];
                    m_tag = command[30:24];
                    m_adr = command[11:0];
                    m_phase = m_we ? 1 : 2;
                    m_cnt = 0;
                end
            end else if (m_phase == 1) begin
                if (cv) begin
                    m_dat = command;
                    m_phase = 2;
                    m_cnt = 0;
                end
            end else if (m_phase == 2) begin
                m_cnt = m_cnt + 1;
                if (err) begin
                    m_resp = 32'd0; m_err = 1'b1; m_phase = 3;
                end else if (ack) begin
                    m_resp = m_we ? 32'd0 : dat_i; m_err = 1'b0; m_phase = 3;
                end else if (m_cnt == TIMEOUT) begin
                    m_resp = 32'd0; m_err = 1'b1; m_phase = 3;
                end
            end else begin
                if (ready) m_phase = 0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs with the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc", 32'(wb_cyc_o), 32'(m_phase == 2));
            chk("stb", 32'(wb_stb_o), 32'(m_phase == 2));
            chk("sel", 32'(wb_sel_o), 32'h0000000F);
            chk("resp_valid", 32'(resp_valid_o), 32'(m_phase == 3));
            chk("drop_count", 32'(drop_count_o), 32'(m_drop));
            if (m_phase == 2) begin
                chk("we", 32'(wb_we_o), 32'(m_we));
                chk("adr", 32'(wb_adr_o), 32'(m_adr));
                if (m_we) chk("wdat", wb_dat_o, m_dat);
            end
            if (m_phase == 3) begin
                chk("resp", resp_o, m_resp);
                chk("resp_tag", 32'(resp_tag_o), 32'(m_tag));
                chk("resp_err", 32'(resp_err_o), 32'(m_err));
            end
        end
    end

    // ------------------------------------------------------------------
    // Target model: responds in the tgt_delay-th strobe cycle (0 = never).
    // ------------------------------------------------------------------
    int          tgt_delay = 0;
    bit          tgt_ack   = 1'b1;
    bit          tgt_err   = 1'b0;
    logic [31:0] tgt_data  = 32'd0;
    int          t_cnt     = 0;

    always @(posedge clk) begin
        #1;
        if (wb_stb_o === 1'b1) begin
            t_cnt++;
            if ((tgt_delay != 0) && (t_cnt == tgt_delay)) begin
                ack = tgt_ack; err = tgt_err; dat_i = tgt_data;
            end else begin
                ack = 1'b0; err = 1'b0; dat_i = $urandom;
            end
        end else begin
            t_cnt = 0; ack = 1'b0; err = 1'b0; dat_i = 32'd0;
        end
    end

    task automatic set_tgt(input int d, input bit a, input bit e, input logic [31:0] data);
        tgt_delay = d; tgt_ack = a; tgt_err = e; tgt_data = data;
    endtask

    task automatic send(input logic [31:0] w);
        @(posedge clk); #1;
        command = w; cv = 1'b1;
        @(posedge clk); #1;
        cv = 1'b0;
    endtask

    // Waits for resp_valid while recording what the bus showed during stb.
    task automatic wait_resp(output int n_stb, output logic [11:0] adr,
                             output logic we, output logic [31:0] wdat, output bit ok);
        n_stb = 0; adr = '0; we = 1'b0; wdat = '0; ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (wb_stb_o === 1'b1) begin
                n_stb++; adr = wb_adr_o; we = wb_we_o; wdat = wb_dat_o;
            end
            if (resp_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_resp no response within 1000 cycles t=%0t", $time);
        end
    endtask

    int          n_stb;
    logic [11:0] s_adr;
    logic        s_we;
    logic [31:0] s_dat;
    bit          ok;
    int          r;

    initial begin
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_resp", resp_o, 32'd0);
        chk("rst_tag", 32'(resp_tag_o), 32'd0);
        chk("rst_err", 32'(resp_err_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_adr", 32'(wb_adr_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_sel", 32'(wb_sel_o), 32'hF);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (4) @(posedge clk);

        // Read with ack in the 4th strobe cycle.
        ready = 1'b1;
        set_tgt(4, 1'b1, 1'b0, 32'h12345678);
        send(32'h05000040);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        chk("rd_stb_cycles", 32'(n_stb), 32'd4);
        chk("rd_adr", 32'(s_adr), 32'h040);
        chk("rd_we", 32'(s_we), 32'd0);
        chk("rd_resp", resp_o, 32'h12345678);
        chk("rd_tag", 32'(resp_tag_o), 32'h05);
        chk("rd_err", 32'(resp_err_o), 32'd0);
        chk("rd_cyc_low_at_valid", 32'(wb_cyc_o), 32'd0);
        chk("model_rd_resp", m_resp, 32'h12345678);
        repeat (3) @(posedge clk);

        // Write.
        set_tgt(2, 1'b1, 1'b0, 32'h0BADF00D);
        send(32'h8A000104);
        send(32'hCAFEBABE);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        chk("wr_adr", 32'(s_adr), 32'h104);
        chk("wr_we", 32'(s_we), 32'd1);
        chk("wr_dat", s_dat, 32'hCAFEBABE);
        chk("wr_sel", 32'(wb_sel_o), 32'hF);
        chk("wr_resp", resp_o, 32'd0);
        chk("wr_tag", 32'(resp_tag_o), 32'h0A);
        chk("wr_err", 32'(resp_err_o), 32'd0);
        repeat (3) @(posedge clk);

        // Timeout: target never answers.
        set_tgt(0, 1'b1, 1'b0, 32'd0);
        send(32'h01000010);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        chk("to_stb_cycles", 32'(n_stb), 32'd255);
        chk("to_err", 32'(resp_err_o), 32'd1);
        chk("to_resp", resp_o, 32'd0);
        repeat (3) @(posedge clk);

        // Ack in the very last permitted cycle wins over the timeout.
        set_tgt(255, 1'b1, 1'b0, 32'hA5A50F0F);
        send(32'h02000011);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        chk("to255_stb_cycles", 32'(n_stb), 32'd255);
        chk("to255_err", 32'(resp_err_o), 32'd0);
        chk("to255_resp", resp_o, 32'hA5A50F0F);
        repeat (3) @(posedge clk);

        // Error and ack together.
        set_tgt(2, 1'b1, 1'b1, 32'hFFFFFFFF);
        send(32'h03000022);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        chk("errack_err", 32'(resp_err_o), 32'd1);
        chk("errack_resp", resp_o, 32'd0);
        chk("errack_tag", 32'(resp_tag_o), 32'h03);
        repeat (3) @(posedge clk);

        // Drops while the response is held.
        ready = 1'b0;
        set_tgt(3, 1'b1, 1'b0, 32'h55AA55AA);
        send(32'h33000200);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            command = 32'h04000000 | 32'(i); cv = 1'b1;
            @(posedge clk); #1;
            cv = 1'b0;
        end
        @(negedge clk);
        chk("drop_sat", 32'(drop_count_o), 32'd255);
        chk("drop_still_valid", 32'(resp_valid_o), 32'd1);
        chk("drop_resp_kept", resp_o, 32'h55AA55AA);
        chk("model_drop", 32'(m_drop), 32'd255);
        ready = 1'b1;
        repeat (2) @(posedge clk);
        set_tgt(2, 1'b1, 1'b0, 32'h0000BEEF);
        send(32'h11000ABC);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        chk("postdrop_adr", 32'(s_adr), 32'hABC);
        chk("postdrop_resp", resp_o, 32'h0000BEEF);
        chk("postdrop_tag", 32'(resp_tag_o), 32'h11);
        repeat (3) @(posedge clk);

        // Reset in the middle of a bus cycle.
        set_tgt(0, 1'b1, 1'b0, 32'd0);
        send(32'h22000123);
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("rstmid_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rstmid_stb", 32'(wb_stb_o), 32'd0);
        chk("rstmid_valid", 32'(resp_valid_o), 32'd0);
        chk("rstmid_drop", 32'(drop_count_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);
        set_tgt(3, 1'b1, 1'b0, 32'h600DCAFE);
        send(32'h7F000FFF);
        wait_resp(n_stb, s_adr, s_we, s_dat, ok);
        chk("postrst_resp", resp_o, 32'h600DCAFE);
        chk("postrst_tag", 32'(resp_tag_o), 32'h7F);
        chk("postrst_err", 32'(resp_err_o), 32'd0);
        repeat (3) @(posedge clk);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            cv = 1'b0;
            ready = ($urandom % 3) != 0;
            if (m_phase == 0 && ($urandom % 4) == 0) begin
                r = int'($urandom % 10);
                set_tgt(int'($urandom_range(1, 6)), r != 0, r <= 1, $urandom);
                command = $urandom; cv = 1'b1;
            end else if (m_phase == 1 && ($urandom % 2) == 0) begin
                command = $urandom; cv = 1'b1;
            end else if (m_phase >= 2 && ($urandom % 8) == 0) begin
                command = $urandom; cv = 1'b1;
            end
        end
        @(posedge clk); #1;
        cv = 1'b0; ready = 1'b1;
        repeat (10) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
